// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared constants for the UART transmit frame controller
package uart_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

    function automatic logic parity_bit(input logic xor_val, input logic par_typ);
        return (par_typ == PAR_EVEN) ? xor_val : ~xor_val;
    endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// rtl/uart_tx_parity_calc.sv - captures frame parity and parity enable at byte accept
module uart_tx_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  accept,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  par_bit,
    output logic                  par_en_q
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
        end else if (accept) begin
            par_bit  <= parity_bit(^p_data, par_typ);
            par_en_q <= par_en;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART TX frame sequencer driving the 8-bit serializer
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  accept_new,
    output logic                  TX_OUT,
    output logic                  busy
);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [1:0] stop_cnt;
    logic       last_stop;
    logic       accept;
    logic       par_bit;
    logic       par_en_q;
    logic       line_lvl;

    assign last_stop = (stop_cnt == 2'(STOP_BITS - 1));
    assign accept    = Data_Valid & accept_new;

    uart_tx_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .CLK     (CLK),
        .RST     (RST),
        .accept  (accept),
        .p_data  (P_DATA),
        .par_en  (PAR_EN),
        .par_typ (PAR_TYP),
        .par_bit (par_bit),
        .par_en_q(par_en_q)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counts stop cycles already spent; reloads to zero on every exit from STOP.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stop_cnt <= 2'd0;
        end else if (state == ST_STOP && !last_stop) begin
            stop_cnt <= stop_cnt + 2'd1;
        end else begin
            stop_cnt <= 2'd0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (Data_Valid) next_state = ST_START;
            ST_START:  next_state = ST_DATA;
            ST_DATA:   if (ser_done) next_state = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: next_state = ST_STOP;
            ST_STOP: begin
                if (last_stop) begin
                    next_state = Data_Valid ? ST_START : ST_IDLE;
                end
            end
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        line_lvl   = LINE_IDLE;
        ser_en     = 1'b0;
        accept_new = 1'b0;
        case (state)
            ST_IDLE:   accept_new = 1'b1;
            ST_START: begin
                line_lvl = 1'b0;
                ser_en   = 1'b1;
            end
            ST_DATA: begin
                line_lvl = ser_data;
                ser_en   = ~ser_done;
            end
            ST_PARITY: line_lvl = par_bit;
            ST_STOP:   accept_new = last_stop;
            default:   line_lvl = LINE_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TX_OUT <= LINE_IDLE;
        end else begin
            TX_OUT <= line_lvl;
        end
    end

endmodule
